// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared types and helpers for the pipelined carry-lookahead adder.
//   CLA_MAX_WIDTH : widest operand the stage record can carry
//   cla_stage_t   : one pipeline stage record (valid, partial z, carry,
//                   residual operand A and inverted operand B)
//   cla_cfg_ok    : configuration legality check (WIDTH a positive multiple
//                   of STAGES, 1 <= STAGES <= WIDTH <= CLA_MAX_WIDTH)
// -----------------------------------------------------------------------------
package cla_pkg;

    localparam int CLA_MAX_WIDTH = 64;

    typedef struct packed {
        logic                     valid;
        logic [CLA_MAX_WIDTH-1:0] z;
        logic                     c;
        logic [CLA_MAX_WIDTH-1:0] a;
        logic [CLA_MAX_WIDTH-1:0] b;
    } cla_stage_t;

    function automatic bit cla_cfg_ok(input int width, input int stages);
        bit ok;
        if (stages < 1) begin
            ok = 1'b0;
        end else begin
            ok = (stages <= width) && (width <= CLA_MAX_WIDTH) && ((width % stages) == 0);
        end
        return ok;
    endfunction

endpackage

// File: rtl/cla_segment.sv
// -----------------------------------------------------------------------------
// cla_segment
// Combinational SEG-bit carry-lookahead adder. Every carry is formed as a flat
// sum of generate terms gated by propagate products, not as a ripple chain.
// Ports:
//   a, b  : SEG-bit operands
//   cin   : carry into bit 0
//   s     : SEG-bit sum
//   cout  : carry out of the top bit
// -----------------------------------------------------------------------------
module cla_segment #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout
);

    logic [SEG-1:0] g_s;
    logic [SEG-1:0] p_s;
    logic [SEG:0]   c_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
    always_comb begin
        logic acc_v;
        logic prod_v;
        c_s    = '0;
        c_s[0] = cin;
        for (int i = 0; i < SEG; i++) begin
            acc_v  = 1'b0;
            prod_v = 1'b1;
            for (int j = i; j >= 0; j--) begin
                acc_v  = acc_v | (prod_v & g_s[j]);
                prod_v = prod_v & p_s[j];
            end
            c_s[i+1] = acc_v | (prod_v & cin);
        end
    end

    assign s    = p_s ^ c_s[SEG-1:0];
    assign cout = c_s[SEG];

endmodule

// File: rtl/cla_pipe.sv
// -----------------------------------------------------------------------------
// cla_pipe
// Pipelined carry-lookahead adder/subtractor. The WIDTH-bit operation is cut
// into STAGES segments of WIDTH/STAGES bits; stage k adds segment k and the
// carry is registered between stages. Latency is STAGES cycles, throughput one
// beat per cycle. A single global advance (adv = !out_valid || out_ready)
// moves the whole pipe, so output data holds while stalled.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : input handshake (in_ready == adv)
//   a, b, ci, sub        : operands, carry-in (ignored for sub), subtract
//   out_valid / out_ready: output handshake
//   z, co                : result and carry-out (for sub: 1 = no borrow)
//   zf, ovf              : zero and signed-overflow flags, only when the
//                          macro CLA_PIPE_FLAGS_EN is defined
// -----------------------------------------------------------------------------
module cla_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             co
`ifdef CLA_PIPE_FLAGS_EN
    ,
    output logic             zf,
    output logic             ovf
`endif
);

    localparam int SEG = (STAGES > 0) ? (WIDTH / STAGES) : 1;

    if (!cla_cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("cla_pipe: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH <= CLA_MAX_WIDTH");
    end

    cla_stage_t              entry_s;
    cla_stage_t [STAGES-1:0] nxt_s;
    cla_stage_t [STAGES-1:0] st_r;
    logic                    adv_s;

    assign adv_s     = !st_r[STAGES-1].valid || out_ready;
    assign in_ready  = adv_s;
    assign out_valid = st_r[STAGES-1].valid;
    assign z         = st_r[STAGES-1].z[WIDTH-1:0];
    assign co        = st_r[STAGES-1].c;

    // Entry record: B inverted for subtract, carry-in forced to 1 for subtract
    always_comb begin
        entry_s              = '0;
        entry_s.valid        = in_valid;
        entry_s.c            = sub ? 1'b1 : ci;
        entry_s.a[WIDTH-1:0] = a;
        entry_s.b[WIDTH-1:0] = b ^ {WIDTH{sub}};
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cla_stage_t     prv_s;
        cla_stage_t     nxt_k_s;
        logic [SEG-1:0] sum_s;
        logic           cout_s;

        if (k == 0) begin : g_first
            assign prv_s = entry_s;
        end else begin : g_next
            assign prv_s = st_r[k-1];
        end

        cla_segment #(
            .SEG (SEG)
        ) u_seg (
            .a    (prv_s.a[k*SEG +: SEG]),
            .b    (prv_s.b[k*SEG +: SEG]),
            .cin  (prv_s.c),
            .s    (sum_s),
            .cout (cout_s)
        );

        // Forward the record, dropping this stage's segment sum into z
        always_comb begin
            nxt_k_s                  = prv_s;
            nxt_k_s.z[k*SEG +: SEG]  = sum_s;
            nxt_k_s.c                = cout_s;
        end

        assign nxt_s[k] = nxt_k_s;
    end

    // Stage registers: whole pipe advances together or holds together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_r <= '0;
        end else if (adv_s) begin
            st_r <= nxt_s;
        end
    end

`ifdef CLA_PIPE_FLAGS_EN
    cla_stage_t last_s;
    logic       zf_r;
    logic       ovf_r;

    assign last_s = nxt_s[STAGES-1];
    assign zf     = zf_r;
    assign ovf    = ovf_r;

    // Flags registered alongside z; overflow compares post-inversion sign bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zf_r  <= 1'b0;
            ovf_r <= 1'b0;
        end else if (adv_s) begin
            zf_r  <= (last_s.z[WIDTH-1:0] == {WIDTH{1'b0}});
            ovf_r <= (last_s.a[WIDTH-1] == last_s.b[WIDTH-1]) &&
                     (last_s.z[WIDTH-1] != last_s.a[WIDTH-1]);
        end
    end
`endif

endmodule

// File: tb/tb_cla_pipe.sv
// -----------------------------------------------------------------------------
// tb_cla_pipe
// Scoreboard bench for cla_pipe. The stimulus thread pushes the expected
// result of every accepted beat; a monitor pops and compares whenever an
// output beat is handed over. Expected values come from plain integer
// arithmetic (a + b + ci, or 2^W + a - b) and signed range checks.
// Define CLA_PIPE_FLAGS_EN to also check zf/ovf.
// -----------------------------------------------------------------------------
module tb_cla_pipe #(
    parameter int STAGES = 4
);

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] z;
        logic         co;
        logic         zf;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] z;
    logic         co;
`ifdef CLA_PIPE_FLAGS_EN
    logic         zf;
    logic         ovf;
`endif

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;

    cla_pipe #(
        .WIDTH  (W),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .co        (co)
`ifdef CLA_PIPE_FLAGS_EN
        ,
        .zf        (zf),
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operation the beat requests
    function automatic exp_t ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                       input logic rci, input logic rsub);
        exp_t         e;
        logic [W:0]   full;
        longint       sr;
        longint       smax;
        longint       smin;
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -(longint'(1) << (W - 1));
        if (rsub) begin
            full = {1'b1, {W{1'b0}}} + {1'b0, ra} - {1'b0, rb};
            sr   = longint'($signed(ra)) - longint'($signed(rb));
        end else begin
            full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rci};
            sr   = longint'($signed(ra)) + longint'($signed(rb)) + longint'(rci);
        end
        e.z   = full[W-1:0];
        e.co  = full[W];
        e.zf  = (full[W-1:0] == {W{1'b0}});
        e.ovf = (sr > smax) || (sr < smin);
        return e;
    endfunction

    // Monitor: compare each handed-over output beat against the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got z=%0h with no beat outstanding", z);
                end else begin
                    e = sb_q.pop_front();
                    chk("z", 64'(z), 64'(e.z));
                    chk("co", 64'(co), 64'(e.co));
`ifdef CLA_PIPE_FLAGS_EN
                    chk("zf", 64'(zf), 64'(e.zf));
                    chk("ovf", 64'(ovf), 64'(e.ovf));
`endif
                    n_out++;
                end
            end
        end
    end

    // One offer of a beat; rnd_rdy randomises out_ready for this cycle
    task automatic drive(input logic [W-1:0] da, input logic [W-1:0] db, input logic dci,
                         input logic dsub, input exp_t e, input bit need_ready,
                         input bit rnd_rdy, output bit acc);
        @(negedge clk);
        if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
        in_valid = 1'b1;
        a        = da;
        b        = db;
        ci       = dci;
        sub      = dsub;
        #1;
        acc = in_ready;
        if (need_ready) chk("in_ready_stream", 64'(in_ready), 64'd1);
        if (acc) sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] da, input logic [W-1:0] db, input logic dci,
                        input logic dsub, input exp_t e, input bit need_ready, input bit rnd_rdy);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 200) begin
            drive(da, db, dci, dsub, e, need_ready, rnd_rdy, acc);
            tries++;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got no accept after %0d tries expected accept", tries);
        end
    endtask

    task automatic send_rand(input bit need_ready, input bit rnd_rdy);
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rci;
        logic         rsub;
        ra   = $urandom();
        rb   = $urandom();
        rci  = 1'($urandom_range(0, 1));
        rsub = 1'($urandom_range(0, 1));
        send(ra, rb, rci, rsub, ref_model(ra, rb, rci, rsub), need_ready, rnd_rdy);
    endtask

    task automatic wait_drain();
        int cnt;
        cnt = 0;
        while (sb_q.size() != 0 && cnt < 1000) begin
            @(posedge clk);
            cnt++;
        end
        chk("drain_outstanding", 64'(sb_q.size()), 64'd0);
        @(negedge clk);
        #3;
    endtask

    // Issue one beat into an empty pipe and count edges until out_valid
    task automatic latency_beat(input logic [W-1:0] da, input logic [W-1:0] db, input logic dci,
                                input logic dsub, input exp_t e);
        int lat;
        send(da, db, dci, dsub, e, 1'b0, 1'b0);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(STAGES));
    endtask

    initial begin
        exp_t e;
        bit   acc;
        int   nacc;
        int   out_before;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        ci        = 1'b0;
        sub       = 1'b0;

        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_z", 64'(z), 64'd0);
        chk("rst_co", 64'(co), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors with hand-derived expectations
        e = '{z: 32'h0000_0000, co: 1'b1, zf: 1'b1, ovf: 1'b0};
        latency_beat(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, e);
        wait_drain();
        e = '{z: 32'hFFFF_FFFE, co: 1'b0, zf: 1'b0, ovf: 1'b0};
        latency_beat(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, e);
        wait_drain();
        e = '{z: 32'h7FFF_FFFF, co: 1'b1, zf: 1'b0, ovf: 1'b1};
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, e, 1'b0, 1'b0);
        e = '{z: 32'h0000_0000, co: 1'b1, zf: 1'b1, ovf: 1'b0};
        send(32'h0000_0003, 32'h0000_0003, 1'b1, 1'b1, e, 1'b0, 1'b0);
        e = '{z: 32'h8000_0000, co: 1'b0, zf: 1'b0, ovf: 1'b1};
        send(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, e, 1'b0, 1'b0);
        wait_drain();

        // Back-to-back random stream at full throughput
        out_before = n_out;
        for (int i = 0; i < 100; i++) send_rand(1'b1, 1'b0);
        wait_drain();
        chk("stream_count", 64'(n_out - out_before), 64'd100);

        // Fill the pipe with the consumer stalled, then hold for 10 cycles
        @(negedge clk);
        out_ready  = 1'b0;
        out_before = n_out;
        nacc       = 0;
        for (int i = 0; i < STAGES + 2; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom();
            rb = $urandom();
            drive(ra, rb, 1'b1, 1'b0, ref_model(ra, rb, 1'b1, 1'b0), 1'b0, 1'b0, acc);
            if (acc) nacc++;
        end
        chk("fill_count", 64'(nacc), 64'(STAGES));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #2;
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_z", 64'(z), 64'(sb_q[0].z));
            chk("stall_co", 64'(co), 64'(sb_q[0].co));
        end
        @(negedge clk);
        out_ready = 1'b1;
        wait_drain();
        chk("stall_out_count", 64'(n_out - out_before), 64'(nacc));

        // Random stream with random consumer back-pressure
        for (int i = 0; i < 150; i++) send_rand(1'b0, 1'b1);
        @(negedge clk);
        out_ready = 1'b1;
        wait_drain();

        // Reset with beats in flight
        for (int i = 0; i < 3; i++) send_rand(1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_z", 64'(z), 64'd0);
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        e = '{z: 32'h1234_5679, co: 1'b0, zf: 1'b0, ovf: 1'b0};
        latency_beat(32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, e);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
